// File: rtl/fpu_request_arbiter.sv
// Round-robin sharing of one add/sub fpu between NREQ requesters, one operation in flight.
// Result returns ~8 (add) / ~10 (sub) cycles after transfer; no new grant while a response is pending.
module fpu_request_arbiter #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [7*NREQ-1:0] req_a_e,
  input  logic [15*NREQ-1:0] req_a_m,
  input  logic [7*NREQ-1:0] req_b_e,
  input  logic [15*NREQ-1:0] req_b_m,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [6:0]        rsp_e,
  output logic [14:0]       rsp_m,
  output logic              rsp_err,
  output logic              fpu_add,
  output logic              fpu_sub,
  output logic [6:0]        fpu_reg1_e,
  output logic [14:0]       fpu_reg1_m,
  output logic [6:0]        fpu_reg2_e,
  output logic [14:0]       fpu_reg2_m,
  input  logic [6:0]        fpu_res_e,
  input  logic [14:0]       fpu_res_m,
  input  logic              fpu_idle,
  output logic              fpu_reset,
  output logic              busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_WBUSY = 3'd3,
    S_WDONE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      boot_cnt_q, boot_cnt_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            op_q, op_d;
  logic [6:0]      a_e_q, a_e_d, b_e_q, b_e_d;
  logic [14:0]     a_m_q, a_m_d, b_m_q, b_m_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [6:0]      rsp_e_q, rsp_e_d;
  logic [14:0]     rsp_m_q, rsp_m_d;
  logic            rsp_err_q, rsp_err_d;
  logic            fpu_reset_q, fpu_reset_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic            sel_op;
  logic [6:0]      sel_a_e, sel_b_e;
  logic [14:0]     sel_a_m, sel_b_m;

  // Requesters above the pointer win first, then wrap around to index 0.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && req_valid[i] && (IDW'(i) > rr_q)) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && req_valid[i] && (IDW'(i) <= rr_q)) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_op  = 1'b0;
    sel_a_e = '0;
    sel_a_m = '0;
    sel_b_e = '0;
    sel_b_m = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[i];
        sel_a_e = req_a_e[7*i +: 7];
        sel_a_m = req_a_m[15*i +: 15];
        sel_b_e = req_b_e[7*i +: 7];
        sel_b_m = req_b_m[15*i +: 15];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      rr_q        <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= 1'b0;
      a_e_q       <= '0;
      a_m_q       <= '0;
      b_e_q       <= '0;
      b_m_q       <= '0;
      wdog_q      <= '0;
      rsp_e_q     <= '0;
      rsp_m_q     <= '0;
      rsp_err_q   <= 1'b0;
      fpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_e_q       <= a_e_d;
      a_m_q       <= a_m_d;
      b_e_q       <= b_e_d;
      b_m_q       <= b_m_d;
      wdog_q      <= wdog_d;
      rsp_e_q     <= rsp_e_d;
      rsp_m_q     <= rsp_m_d;
      rsp_err_q   <= rsp_err_d;
      fpu_reset_q <= fpu_reset_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    rr_d        = rr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_e_d       = a_e_q;
    a_m_d       = a_m_q;
    b_e_d       = b_e_q;
    b_m_d       = b_m_q;
    wdog_d      = wdog_q;
    rsp_e_d     = rsp_e_q;
    rsp_m_d     = rsp_m_q;
    rsp_err_d   = rsp_err_q;
    fpu_reset_d = 1'b0;
    case (state_q)
      // fpu_idle is unknown right after an fpu reset; let it settle before trusting it.
      S_BOOT: begin
        if (boot_cnt_q != 2'd2) begin
          boot_cnt_d = boot_cnt_q + 2'd1;
        end else if (fpu_idle) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (grant_vld) begin
          id_d    = grant_id;
          rr_d    = grant_id;
          op_d    = sel_op;
          a_e_d   = sel_a_e;
          a_m_d   = sel_a_m;
          b_e_d   = sel_b_e;
          b_m_d   = sel_b_m;
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WBUSY;
      end
      S_WBUSY, S_WDONE: begin
        if ((state_q == S_WDONE) && fpu_idle) begin
          rsp_e_d   = fpu_res_e;
          rsp_m_d   = fpu_res_m;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          fpu_reset_d = 1'b1;
          rsp_e_d     = '0;
          rsp_m_d     = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if ((state_q == S_WBUSY) && !fpu_idle) begin
            state_d = S_WDONE;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          // After a timeout the fpu was reset, so re-run the boot wait before granting.
          state_d    = rsp_err_q ? S_BOOT : S_IDLE;
          boot_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_BOOT;
        boot_cnt_d = '0;
      end
    endcase
  end

  // busy stays low in S_BOOT so that reset leaves every output low.
  always_comb begin
    req_ready  = (state_q == S_IDLE) ? grant : '0;
    fpu_add    = (state_q == S_START) && !op_q;
    fpu_sub    = (state_q == S_START) && op_q;
    rsp_valid  = (state_q == S_RESP);
    busy       = (state_q != S_IDLE) && (state_q != S_BOOT);
    rsp_id     = id_q;
    rsp_e      = rsp_e_q;
    rsp_m      = rsp_m_q;
    rsp_err    = rsp_err_q;
    fpu_reg1_e = a_e_q;
    fpu_reg1_m = a_m_q;
    fpu_reg2_e = b_e_q;
    fpu_reg2_m = b_m_q;
    fpu_reset  = fpu_reset_q;
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_hold
    a_no_withdraw: assert property (@(posedge clk) disable iff (reset)
      (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
  end

endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Bench for fpu_request_arbiter: stub fpu, per-requester driver queues, scoreboard monitor.
module tb_fpu_request_arbiter;
  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int TIMEOUT = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, req_op;
  logic [7*NREQ-1:0] req_a_e, req_b_e;
  logic [15*NREQ-1:0] req_a_m, req_b_m;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]    rsp_id;
  logic [6:0]        rsp_e, fpu_reg1_e, fpu_reg2_e, fpu_res_e;
  logic [14:0]       rsp_m, fpu_reg1_m, fpu_reg2_m, fpu_res_m;
  logic              fpu_add, fpu_sub, fpu_idle, fpu_reset, busy;
  logic              hang;

  fpu_request_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a_e(req_a_e), .req_a_m(req_a_m), .req_b_e(req_b_e), .req_b_m(req_b_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_e(rsp_e), .rsp_m(rsp_m), .rsp_err(rsp_err),
    .fpu_add(fpu_add), .fpu_sub(fpu_sub),
    .fpu_reg1_e(fpu_reg1_e), .fpu_reg1_m(fpu_reg1_m),
    .fpu_reg2_e(fpu_reg2_e), .fpu_reg2_m(fpu_reg2_m),
    .fpu_res_e(fpu_res_e), .fpu_res_m(fpu_res_m),
    .fpu_idle(fpu_idle), .fpu_reset(fpu_reset), .busy(busy)
  );

  typedef struct { logic op; logic [6:0] ae; logic [14:0] am; logic [6:0] be; logic [14:0] bm; } op_t;
  typedef struct { logic [IDW-1:0] id; logic [6:0] e; logic [14:0] m; logic err; logic op; } exp_t;

  op_t  rq0[$];
  op_t  rq1[$];
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  int n_add = 0, n_sub = 0, n_rst = 0;
  longint t_start = 0, t_rst = 0;
  logic trk = 1'b0, stb_ok = 1'b1;
  logic [43:0] cap_ops;
  logic [NREQ-1:0] drv_x;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic op_t mk(input logic op, input logic [6:0] ae, input logic [14:0] am,
                             input logic [6:0] be, input logic [14:0] bm);
    op_t o;
    o.op = op; o.ae = ae; o.am = am; o.be = be; o.bm = bm;
    return o;
  endfunction

  function automatic exp_t ex(input logic [IDW-1:0] id, input logic [6:0] e, input logic [14:0] m,
                              input logic err, input logic op);
    exp_t x;
    x.id = id; x.e = e; x.m = m; x.err = err; x.op = op;
    return x;
  endfunction

  task automatic push(input int r, input op_t o, input exp_t x);
    if (r == 0) rq0.push_back(o);
    else rq1.push_back(o);
    sb.push_back(x);
  endtask

  // Stub fpu arithmetic: explicit leading one at mantissa bit 14.
  function automatic logic [21:0] fp_calc(input logic sub, input logic [6:0] ae, input logic [14:0] am,
                                          input logic [6:0] be, input logic [14:0] bm);
    logic [6:0]  e;
    logic [15:0] x, y, s;
    if (ae >= be) begin e = ae; x = {1'b0, am}; y = {1'b0, bm} >> (ae - be); end
    else begin e = be; x = {1'b0, bm}; y = {1'b0, am} >> (be - ae); end
    s = sub ? x - y : x + y;
    if (s[15]) begin
      s = s >> 1;
      e = e + 7'd1;
    end else begin
      for (int k = 0; k < 14; k++) begin
        if (s != 16'd0 && !s[14]) begin
          s = s << 1;
          e = e - 7'd1;
        end
      end
    end
    return {e, s[14:0]};
  endfunction

  // Stub fpu: idle stays high the cycle after start, then low for a few cycles.
  logic [1:0] ph;
  int         fcnt;
  logic       cur_sub;
  always @(posedge clk) begin
    if (reset || fpu_reset) begin
      ph <= 2'd0; fpu_idle <= 1'b0; fcnt <= 0; cur_sub <= 1'b0;
      fpu_res_e <= '0; fpu_res_m <= '0;
    end else if (hang) begin
      fpu_idle <= 1'b1;
    end else begin
      case (ph)
        2'd0: begin
          fpu_idle <= 1'b1;
          if (fpu_add || fpu_sub) begin ph <= 2'd1; cur_sub <= fpu_sub; end
        end
        2'd1: begin fpu_idle <= 1'b0; ph <= 2'd2; fcnt <= cur_sub ? 6 : 4; end
        default: begin
          if (fcnt == 0) begin
            {fpu_res_e, fpu_res_m} <= fp_calc(cur_sub, fpu_reg1_e, fpu_reg1_m, fpu_reg2_e, fpu_reg2_m);
            fpu_idle <= 1'b1;
            ph <= 2'd0;
          end else begin
            fcnt <= fcnt - 1;
          end
        end
      endcase
    end
  end

  // Requester driver: present queue heads, pop after an observed transfer.
  initial begin
    op_t h;
    req_valid = '0; req_op = '0; req_a_e = '0; req_a_m = '0; req_b_e = '0; req_b_m = '0;
    forever begin
      @(negedge clk);
      drv_x = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (drv_x[0]) void'(rq0.pop_front());
      if (drv_x[1]) void'(rq1.pop_front());
      req_valid = '0; req_op = '0; req_a_e = '0; req_a_m = '0; req_b_e = '0; req_b_m = '0;
      if (rq0.size() > 0) begin
        h = rq0[0];
        req_valid[0] = 1'b1; req_op[0] = h.op;
        req_a_e[6:0] = h.ae; req_a_m[14:0] = h.am; req_b_e[6:0] = h.be; req_b_m[14:0] = h.bm;
      end
      if (rq1.size() > 0) begin
        h = rq1[0];
        req_valid[1] = 1'b1; req_op[1] = h.op;
        req_a_e[13:7] = h.ae; req_a_m[29:15] = h.am; req_b_e[13:7] = h.be; req_b_m[29:15] = h.bm;
      end
    end
  end

  // Monitor: start pulses, operand stability, fpu_reset pulses, response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fpu_add) n_add++;
        if (fpu_sub) n_sub++;
        if (fpu_add || fpu_sub) begin
          t_start = cyc; trk = 1'b1; stb_ok = 1'b1;
          cap_ops = {fpu_reg1_e, fpu_reg1_m, fpu_reg2_e, fpu_reg2_m};
        end else if (trk && ({fpu_reg1_e, fpu_reg1_m, fpu_reg2_e, fpu_reg2_m} !== cap_ops)) begin
          stb_ok = 1'b0;
        end
        if (fpu_reset) begin n_rst++; t_rst = cyc; end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected id=%0d e=0x%0h m=0x%0h err=%0b", rsp_id, rsp_e, rsp_m, rsp_err);
          end else begin
            e = sb.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_e", 64'(rsp_e), 64'(e.e));
            check("rsp_m", 64'(rsp_m), 64'(e.m));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("add_pulses", 64'(n_add), e.op ? 64'd0 : 64'd1);
            check("sub_pulses", 64'(n_sub), e.op ? 64'd1 : 64'd0);
            check("opnd_stable", 64'(stb_ok), 64'd1);
          end
          n_add = 0; n_sub = 0; trk = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_id, rsp_err, fpu_add, fpu_sub, fpu_reset, busy}), 64'd0);
    check({tag, "_rsp"}, 64'({rsp_e, rsp_m}), 64'd0);
    check({tag, "_reg1"}, 64'({fpu_reg1_e, fpu_reg1_m}), 64'd0);
    check({tag, "_reg2"}, 64'({fpu_reg2_e, fpu_reg2_m}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    reset = 1'b1; rsp_ready = 1'b1; hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // 1: add on requester 0
    push(0, mk(1'b0, 7'd0, 15'h4000, 7'd0, 15'h4000), ex(1'b0, 7'd1, 15'h4000, 1'b0, 1'b0));
    wait_drain(100);

    // 2: sub on requester 1
    @(posedge clk); #1;
    push(1, mk(1'b1, 7'd3, 15'h4000, 7'd3, 15'h2000), ex(1'b1, 7'd2, 15'h4000, 1'b0, 1'b1));
    wait_drain(100);

    // 3: fairness, both requesters held valid for six operations
    @(posedge clk); #1;
    push(0, mk(1'b0, 7'd1, 15'h4000, 7'd1, 15'h4000), ex(1'b0, 7'd2, 15'h4000, 1'b0, 1'b0));
    push(1, mk(1'b0, 7'd5, 15'h4000, 7'd5, 15'h2000), ex(1'b1, 7'd5, 15'h6000, 1'b0, 1'b0));
    push(0, mk(1'b0, 7'd2, 15'h4000, 7'd1, 15'h4000), ex(1'b0, 7'd2, 15'h6000, 1'b0, 1'b0));
    push(1, mk(1'b1, 7'd2, 15'h7000, 7'd2, 15'h1000), ex(1'b1, 7'd2, 15'h6000, 1'b0, 1'b1));
    push(0, mk(1'b1, 7'd4, 15'h6000, 7'd3, 15'h4000), ex(1'b0, 7'd4, 15'h4000, 1'b0, 1'b1));
    push(1, mk(1'b0, 7'd0, 15'h4000, 7'd0, 15'h4000), ex(1'b1, 7'd1, 15'h4000, 1'b0, 1'b0));
    wait_drain(400);

    // 4: backpressure with a second request waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    push(0, mk(1'b0, 7'd1, 15'h4000, 7'd1, 15'h4000), ex(1'b0, 7'd2, 15'h4000, 1'b0, 1'b0));
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    push(1, mk(1'b0, 7'd3, 15'h4000, 7'd3, 15'h4000), ex(1'b1, 7'd4, 15'h4000, 1'b0, 1'b0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold", 64'({rsp_valid, rsp_id, rsp_e, rsp_m, req_ready, fpu_add, fpu_sub}),
            64'({1'b1, 1'b0, 7'd2, 15'h4000, 2'b00, 1'b0, 1'b0}));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'd2);
    wait_drain(100);

    // 5: hung fpu, watchdog recovery
    @(posedge clk); #1;
    hang = 1'b1; n_rst = 0;
    push(0, mk(1'b0, 7'd1, 15'h4000, 7'd1, 15'h4000), ex(1'b0, 7'd0, 15'h0000, 1'b1, 1'b0));
    wait_drain(200);
    repeat (4) @(negedge clk);
    check("wdog_delay", 64'(t_rst - t_start), 64'(TIMEOUT + 1));
    check("rst_pulses", 64'(n_rst), 64'd1);
    @(posedge clk); #1 hang = 1'b0;

    // 6: reset while waiting for the fpu to finish
    push(1, mk(1'b1, 7'd3, 15'h4000, 7'd3, 15'h2000), ex(1'b1, 7'd2, 15'h4000, 1'b0, 1'b1));
    n = 0;
    while (fpu_idle !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("mid_op_fpu_busy", 64'(fpu_idle), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    trk = 1'b0; n_add = 0; n_sub = 0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1 reset = 1'b0;
    push(0, mk(1'b0, 7'd0, 15'h4000, 7'd0, 15'h4000), ex(1'b0, 7'd1, 15'h4000, 1'b0, 1'b0));
    wait_drain(100);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
